control_pipeline: RTL and testbench
===================================

// Module: control_pipeline
// PURPOSE
//  Carries the decoded control bundle from ID through the ID/EX, EX/MEM and MEM/WB stages.
//  Consumes the outputs of the opcode/funct decoder and drives the per-stage enables.
//  Resolves hazards for the 5-stage MIPS pipeline: load-use stall with bubble insertion,
//  flushes on branch/jump, and EX-stage forwarding selects.
//  Sits between the decoder and the datapath stage registers.
// PARAMETERS
//  REG_W    5   register-address width
//  ALUOP_W  3   ALUOp width, passed through unchanged
// PORTS
//  clk            in   1        single clock, rising edge
//  reset          in   1        synchronous, active-high
//  id_RegDst      in   1        decoder control bundle, ID stage
//  id_ALUSrc      in   1        "
//  id_MemtoReg    in   1        1 = write ALU result, 0 = write memory data; passed through, never inverted
//  id_RegWrite    in   1        "
//  id_MemRead     in   1        "
//  id_MemWrite    in   1        "
//  id_BranchEQ    in   1        "
//  id_BranchNE    in   1        "
//  id_ALUOp       in   ALUOP_W  "
//  id_Jump        in   1        J/JAL decoded in ID
//  id_Jr          in   1        JR decoded in ID
//  id_Jal         in   1        forces write address 31
//  id_rs          in   REG_W    instruction fields of the ID instruction
//  id_rt          in   REG_W    "
//  id_rd          in   REG_W    "
//  ex_zero        in   1        ALU zero flag for the EX instruction
//  ex_RegDst      out  1        EX-stage controls (registered)
//  ex_ALUSrc      out  1        "
//  ex_ALUOp       out  ALUOP_W  "
//  mem_MemRead    out  1        MEM-stage controls (registered)
//  mem_MemWrite   out  1        "
//  wb_RegWrite    out  1        WB-stage controls (registered)
//  wb_MemtoReg    out  1        "
//  wb_wr_addr     out  REG_W    register-file write address
//  branch_taken   out  1        combinational; EX branch resolved taken
//  pc_write       out  1        combinational; 0 = hold PC
//  if_id_write    out  1        combinational; 0 = hold IF/ID
//  if_id_flush    out  1        combinational; 1 = IF/ID becomes a NOP
//  forward_a      out  2        00 = regfile, 10 = EX/MEM, 01 = MEM/WB
//  forward_b      out  2        same encoding, for the rt operand
// BEHAVIOUR
//  Reset and bubbles
//  - Reset: every stage register is 0, including all controls, addresses, ex_rs and ex_rt.
//  - Reset therefore yields three bubbles and forward_a = forward_b = 00.
//  - Reset mid-operation discards all in-flight controls on that edge.
//  Latency
//  - An ID bundle appears on ex_* 1 cycle later, on mem_* 2 cycles later, on wb_* 3 cycles later.
//  Write address
//  - Computed on ID->EX: id_Jal ? 31 : (id_RegDst ? id_rd : id_rt).
//  - Piped to mem_wr_addr and wb_wr_addr internally.
//  Load-use stall
//  - Stall = ex_MemRead & ex_wr_addr != 0 & (ex_wr_addr == id_rs | ex_wr_addr == id_rt).
//  - On stall: pc_write = 0 and if_id_write = 0, and the ID/EX stage loads all-zero controls (bubble).
//  - EX/MEM and MEM/WB advance normally during a stall.
//  Branch resolution (EX)
//  - branch_taken = (ex_BranchEQ & ex_zero) | (ex_BranchNE & ~ex_zero).
//  - When taken: if_id_flush = 1 and ID/EX loads a bubble on the next edge.
//  Jumps (ID)
//  - id_Jump | id_Jr asserts if_id_flush when not stalled. ID/EX still loads the jump's bundle.
//  Priority
//  - branch_taken overrides stall: stall is ignored and pc_write = 1.
//  - The two conditions cannot genuinely coexist, since a load is never a branch.
//  - A stall suppresses a jump flush; the jump re-presents next cycle.
//  Forwarding (per operand; shown for rs/forward_a, likewise rt/forward_b)
//  - 10 if mem_RegWrite & mem_wr_addr != 0 & mem_wr_addr == ex_rs.
//  - Else 01 if wb_RegWrite & wb_wr_addr != 0 & wb_wr_addr == ex_rs.
//  - Else 00. EX/MEM always wins a double hit.
//  Register 0
//  - Register 0 never stalls and never forwards.
// TESTING
//  - Reset held 2 cycles -> all outputs 0 except pc_write = if_id_write = 1; forward_* = 00.
//  - LW $t0 (rt=8) then ADD rs=8 -> 1 cycle pc_write = 0 and a bubble in EX; forward_a = 01 the next cycle.
//  - ADD rd=9, then SUB rs=9, rt=9 -> forward_a = forward_b = 10 in the SUB's EX cycle.
//  - BEQ with ex_zero = 1 -> branch_taken = 1, if_id_flush = 1, next ex_* all 0; with ex_zero = 0 -> no flush.
//  - JAL in ID -> if_id_flush = 1; 3 cycles later wb_wr_addr = 31 and wb_RegWrite = 1.
//  - Assert reset while LW is in MEM -> next cycle mem_MemRead = 0 and wb_RegWrite = 0.

Source files
------------

// File: rtl/control_pipeline_if.sv
// Control/hazard bundle between the ID-stage decoder, the datapath stage registers and the pipeline controller.
// master = decoder/datapath side, slave = control_pipeline.
interface control_pipeline_if #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
);
    logic               id_RegDst;
    logic               id_ALUSrc;
    logic               id_MemtoReg;
    logic               id_RegWrite;
    logic               id_MemRead;
    logic               id_MemWrite;
    logic               id_BranchEQ;
    logic               id_BranchNE;
    logic [ALUOP_W-1:0] id_ALUOp;
    logic               id_Jump;
    logic               id_Jr;
    logic               id_Jal;
    logic [REG_W-1:0]   id_rs;
    logic [REG_W-1:0]   id_rt;
    logic [REG_W-1:0]   id_rd;
    logic               ex_zero;

    logic               ex_RegDst;
    logic               ex_ALUSrc;
    logic [ALUOP_W-1:0] ex_ALUOp;
    logic               mem_MemRead;
    logic               mem_MemWrite;
    logic               wb_RegWrite;
    logic               wb_MemtoReg;
    logic [REG_W-1:0]   wb_wr_addr;
    logic               branch_taken;
    logic               pc_write;
    logic               if_id_write;
    logic               if_id_flush;
    logic [1:0]         forward_a;
    logic [1:0]         forward_b;

    modport master (
        output id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
               id_BranchEQ, id_BranchNE, id_ALUOp, id_Jump, id_Jr, id_Jal,
               id_rs, id_rt, id_rd, ex_zero,
        input  ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, wb_wr_addr, branch_taken, pc_write,
               if_id_write, if_id_flush, forward_a, forward_b
    );

    modport slave (
        input  id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite,
               id_BranchEQ, id_BranchNE, id_ALUOp, id_Jump, id_Jr, id_Jal,
               id_rs, id_rt, id_rd, ex_zero,
        output ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite,
               wb_RegWrite, wb_MemtoReg, wb_wr_addr, branch_taken, pc_write,
               if_id_write, if_id_flush, forward_a, forward_b
    );
endinterface

// File: rtl/control_pipeline.sv
// 5-stage MIPS control pipeline: carries decoded controls ID->EX->MEM->WB and resolves
// load-use stalls, branch/jump flushes and EX-stage forwarding selects.
module control_pipeline #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    control_pipeline_if.slave  bus
);
    typedef struct packed {
        logic               reg_dst;
        logic               alu_src;
        logic [ALUOP_W-1:0] alu_op;
        logic               mem_to_reg;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               branch_eq;
        logic               branch_ne;
        logic [REG_W-1:0]   wr_addr;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
    } id_ex_t;

    typedef struct packed {
        logic             mem_to_reg;
        logic             reg_write;
        logic             mem_read;
        logic             mem_write;
        logic [REG_W-1:0] wr_addr;
    } ex_mem_t;

    typedef struct packed {
        logic             mem_to_reg;
        logic             reg_write;
        logic [REG_W-1:0] wr_addr;
    } mem_wb_t;

    id_ex_t  id_ex_d,  id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;
    id_ex_t  id_bundle;

    logic load_use;
    logic taken;
    logic stall;
    logic bubble;

    // Register 0 is hard-wired, so it never sources a forward.
    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                           input ex_mem_t m, input mem_wb_t w);
        if (m.reg_write && (m.wr_addr != '0) && (m.wr_addr == src))
            return 2'b10;
        else if (w.reg_write && (w.wr_addr != '0) && (w.wr_addr == src))
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        id_bundle            = '0;
        id_bundle.reg_dst    = bus.id_RegDst;
        id_bundle.alu_src    = bus.id_ALUSrc;
        id_bundle.alu_op     = bus.id_ALUOp;
        id_bundle.mem_to_reg = bus.id_MemtoReg;
        id_bundle.reg_write  = bus.id_RegWrite;
        id_bundle.mem_read   = bus.id_MemRead;
        id_bundle.mem_write  = bus.id_MemWrite;
        id_bundle.branch_eq  = bus.id_BranchEQ;
        id_bundle.branch_ne  = bus.id_BranchNE;
        id_bundle.wr_addr    = bus.id_Jal ? REG_W'(31) : (bus.id_RegDst ? bus.id_rd : bus.id_rt);
        id_bundle.rs         = bus.id_rs;
        id_bundle.rt         = bus.id_rt;

        load_use = id_ex_q.mem_read && (id_ex_q.wr_addr != '0) &&
                   ((id_ex_q.wr_addr == bus.id_rs) || (id_ex_q.wr_addr == bus.id_rt));
        taken    = (id_ex_q.branch_eq && bus.ex_zero) || (id_ex_q.branch_ne && !bus.ex_zero);
        // A resolved branch squashes the ID instruction anyway, so its stall is moot.
        stall    = load_use && !taken;
        bubble   = stall || taken;

        id_ex_d  = bubble ? '0 : id_bundle;

        ex_mem_d            = '0;
        ex_mem_d.mem_to_reg = id_ex_q.mem_to_reg;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.wr_addr    = id_ex_q.wr_addr;

        mem_wb_d            = '0;
        mem_wb_d.mem_to_reg = ex_mem_q.mem_to_reg;
        mem_wb_d.reg_write  = ex_mem_q.reg_write;
        mem_wb_d.wr_addr    = ex_mem_q.wr_addr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign bus.ex_RegDst    = id_ex_q.reg_dst;
    assign bus.ex_ALUSrc    = id_ex_q.alu_src;
    assign bus.ex_ALUOp     = id_ex_q.alu_op;
    assign bus.mem_MemRead  = ex_mem_q.mem_read;
    assign bus.mem_MemWrite = ex_mem_q.mem_write;
    assign bus.wb_RegWrite  = mem_wb_q.reg_write;
    assign bus.wb_MemtoReg  = mem_wb_q.mem_to_reg;
    assign bus.wb_wr_addr   = mem_wb_q.wr_addr;
    assign bus.branch_taken = taken;
    assign bus.pc_write     = !stall;
    assign bus.if_id_write  = !stall;
    // A stalled jump re-presents next cycle, so its flush waits until then.
    assign bus.if_id_flush  = taken || ((bus.id_Jump || bus.id_Jr) && !stall);
    assign bus.forward_a    = fwd_sel(id_ex_q.rs, ex_mem_q, mem_wb_q);
    assign bus.forward_b    = fwd_sel(id_ex_q.rt, ex_mem_q, mem_wb_q);
endmodule

// File: tb/tb_control_pipeline.sv
// Directed bench for control_pipeline: reset, load-use stall, forwarding, branch/jump flush, mid-run reset.
module tb_control_pipeline;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int errors = 0;

    control_pipeline_if #(.REG_W(5), .ALUOP_W(3)) bus ();
    control_pipeline #(.REG_W(5), .ALUOP_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        bus.id_RegDst = 0; bus.id_ALUSrc = 0; bus.id_MemtoReg = 0; bus.id_RegWrite = 0;
        bus.id_MemRead = 0; bus.id_MemWrite = 0; bus.id_BranchEQ = 0; bus.id_BranchNE = 0;
        bus.id_ALUOp = 3'b000; bus.id_Jump = 0; bus.id_Jr = 0; bus.id_Jal = 0;
        bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rd = 5'd0; bus.ex_zero = 0;
    endtask

    task automatic drain();
        clear_id();
        repeat (3) tick();
    endtask

    task automatic set_alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        clear_id();
        bus.id_RegDst = 1; bus.id_RegWrite = 1; bus.id_MemtoReg = 1; bus.id_ALUOp = 3'b010;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    endtask

    task automatic set_lw(input logic [4:0] rs, input logic [4:0] rt);
        clear_id();
        bus.id_ALUSrc = 1; bus.id_RegWrite = 1; bus.id_MemRead = 1; bus.id_MemtoReg = 0;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = 5'd0;
    endtask

    task automatic test_reset();
        clear_id();
        reset = 1;
        bus.id_RegWrite = 1; bus.id_RegDst = 1; bus.id_rd = 5'd5; bus.id_MemRead = 1; bus.id_ALUOp = 3'b111;
        tick(); tick();
        checks++; if (bus.ex_RegDst !== 1'b0) begin errors++; $display("FAIL rst_ex_RegDst got %b exp 0", bus.ex_RegDst); end
        checks++; if (bus.ex_ALUOp !== 3'b000) begin errors++; $display("FAIL rst_ex_ALUOp got %b exp 000", bus.ex_ALUOp); end
        checks++; if (bus.mem_MemRead !== 1'b0) begin errors++; $display("FAIL rst_mem_MemRead got %b exp 0", bus.mem_MemRead); end
        checks++; if (bus.wb_RegWrite !== 1'b0) begin errors++; $display("FAIL rst_wb_RegWrite got %b exp 0", bus.wb_RegWrite); end
        checks++; if (bus.wb_wr_addr !== 5'd0) begin errors++; $display("FAIL rst_wb_wr_addr got %0d exp 0", bus.wb_wr_addr); end
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1) begin errors++; $display("FAIL rst_write got pc=%b ifid=%b exp 1 1", bus.pc_write, bus.if_id_write); end
        checks++; if (bus.if_id_flush !== 1'b0 || bus.branch_taken !== 1'b0) begin errors++; $display("FAIL rst_flush got flush=%b taken=%b exp 0 0", bus.if_id_flush, bus.branch_taken); end
        checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL rst_fwd got %b %b exp 00 00", bus.forward_a, bus.forward_b); end
        clear_id();
        reset = 0;
    endtask

    task automatic test_load_use();
        drain();
        set_lw(5'd29, 5'd8);
        tick();
        set_alu(5'd8, 5'd10, 5'd11);
        #1;
        checks++; if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0) begin errors++; $display("FAIL lu_stall got pc=%b ifid=%b exp 0 0", bus.pc_write, bus.if_id_write); end
        checks++; if (bus.ex_ALUSrc !== 1'b1) begin errors++; $display("FAIL lu_ex_lw got %b exp 1", bus.ex_ALUSrc); end
        tick();
        checks++; if (bus.ex_ALUSrc !== 1'b0 || bus.ex_RegDst !== 1'b0 || bus.ex_ALUOp !== 3'b000) begin errors++; $display("FAIL lu_bubble got %b %b %b exp 0 0 000", bus.ex_ALUSrc, bus.ex_RegDst, bus.ex_ALUOp); end
        checks++; if (bus.mem_MemRead !== 1'b1) begin errors++; $display("FAIL lu_mem_advance got %b exp 1", bus.mem_MemRead); end
        checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL lu_release got %b exp 1", bus.pc_write); end
        tick();
        clear_id();
        #1;
        checks++; if (bus.ex_RegDst !== 1'b1 || bus.ex_ALUOp !== 3'b010) begin errors++; $display("FAIL lu_add_ex got %b %b exp 1 010", bus.ex_RegDst, bus.ex_ALUOp); end
        checks++; if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL lu_fwd got %b %b exp 01 00", bus.forward_a, bus.forward_b); end
        checks++; if (bus.wb_RegWrite !== 1'b1 || bus.wb_MemtoReg !== 1'b0 || bus.wb_wr_addr !== 5'd8) begin errors++; $display("FAIL lu_wb got %b %b %0d exp 1 0 8", bus.wb_RegWrite, bus.wb_MemtoReg, bus.wb_wr_addr); end
        // Load to $zero must not stall.
        drain();
        set_lw(5'd29, 5'd0);
        tick();
        set_alu(5'd0, 5'd0, 5'd3);
        #1;
        checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL lu_r0_nostall got %b exp 1", bus.pc_write); end
        clear_id();
    endtask

    task automatic test_forwarding();
        drain();
        set_alu(5'd1, 5'd2, 5'd9);  tick();
        set_alu(5'd3, 5'd4, 5'd9);  tick();
        set_alu(5'd9, 5'd9, 5'd12); tick();
        checks++; if (bus.forward_a !== 2'b10 || bus.forward_b !== 2'b10) begin errors++; $display("FAIL fwd_exmem got %b %b exp 10 10", bus.forward_a, bus.forward_b); end
        set_alu(5'd9, 5'd12, 5'd13); tick();
        checks++; if (bus.forward_a !== 2'b01 || bus.forward_b !== 2'b10) begin errors++; $display("FAIL fwd_mixed got %b %b exp 01 10", bus.forward_a, bus.forward_b); end
        set_alu(5'd0, 5'd0, 5'd0); tick();
        set_alu(5'd0, 5'd0, 5'd14); tick();
        checks++; if (bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin errors++; $display("FAIL fwd_r0 got %b %b exp 00 00", bus.forward_a, bus.forward_b); end
        clear_id();
    endtask

    task automatic test_branch();
        drain();
        bus.id_BranchEQ = 1; bus.id_ALUOp = 3'b001; bus.id_rs = 5'd1; bus.id_rt = 5'd2;
        tick();
        set_alu(5'd3, 5'd4, 5'd5);
        bus.ex_zero = 1;
        #1;
        checks++; if (bus.branch_taken !== 1'b1 || bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL br_taken got %b %b exp 1 1", bus.branch_taken, bus.if_id_flush); end
        tick();
        bus.ex_zero = 0;
        #1;
        checks++; if (bus.ex_RegDst !== 1'b0 || bus.ex_ALUOp !== 3'b000 || bus.ex_ALUSrc !== 1'b0) begin errors++; $display("FAIL br_bubble got %b %b %b exp 0 000 0", bus.ex_RegDst, bus.ex_ALUOp, bus.ex_ALUSrc); end
        clear_id();
        bus.id_BranchEQ = 1; bus.id_ALUOp = 3'b001;
        tick();
        set_alu(5'd3, 5'd4, 5'd5);
        bus.ex_zero = 0;
        #1;
        checks++; if (bus.branch_taken !== 1'b0 || bus.if_id_flush !== 1'b0) begin errors++; $display("FAIL br_not_taken got %b %b exp 0 0", bus.branch_taken, bus.if_id_flush); end
        tick();
        checks++; if (bus.ex_RegDst !== 1'b1 || bus.ex_ALUOp !== 3'b010) begin errors++; $display("FAIL br_fallthru got %b %b exp 1 010", bus.ex_RegDst, bus.ex_ALUOp); end
        clear_id();
        bus.id_BranchNE = 1;
        tick();
        clear_id();
        bus.ex_zero = 0;
        #1;
        checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL bne_taken got %b exp 1", bus.branch_taken); end
        // Forced overlap of load and branch: the branch must win.
        clear_id();
        tick();
        bus.id_MemRead = 1; bus.id_BranchEQ = 1; bus.id_rt = 5'd8;
        tick();
        set_alu(5'd8, 5'd1, 5'd2);
        bus.ex_zero = 1;
        #1;
        checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1 || bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL br_over_stall got %b %b %b exp 1 1 1", bus.pc_write, bus.if_id_write, bus.if_id_flush); end
        clear_id();
    endtask

    task automatic test_jump();
        drain();
        bus.id_Jump = 1; bus.id_Jal = 1; bus.id_RegWrite = 1; bus.id_MemtoReg = 1; bus.id_rt = 5'd7; bus.id_rd = 5'd6;
        #1;
        checks++; if (bus.if_id_flush !== 1'b1 || bus.pc_write !== 1'b1) begin errors++; $display("FAIL jal_flush got %b %b exp 1 1", bus.if_id_flush, bus.pc_write); end
        tick();
        clear_id();
        tick(); tick();
        checks++; if (bus.wb_wr_addr !== 5'd31 || bus.wb_RegWrite !== 1'b1 || bus.wb_MemtoReg !== 1'b1) begin errors++; $display("FAIL jal_wb got %0d %b %b exp 31 1 1", bus.wb_wr_addr, bus.wb_RegWrite, bus.wb_MemtoReg); end
        drain();
        set_lw(5'd29, 5'd8);
        tick();
        clear_id();
        bus.id_Jr = 1; bus.id_rs = 5'd8;
        #1;
        checks++; if (bus.if_id_flush !== 1'b0 || bus.pc_write !== 1'b0) begin errors++; $display("FAIL jr_stalled got %b %b exp 0 0", bus.if_id_flush, bus.pc_write); end
        tick();
        checks++; if (bus.if_id_flush !== 1'b1) begin errors++; $display("FAIL jr_replay got %b exp 1", bus.if_id_flush); end
        clear_id();
    endtask

    task automatic test_back_to_back_reset();
        drain();
        clear_id();
        bus.id_MemWrite = 1; bus.id_ALUSrc = 1;
        tick();
        set_lw(5'd29, 5'd8);
        tick();
        clear_id();
        #1;
        checks++; if (bus.mem_MemWrite !== 1'b1 || bus.mem_MemRead !== 1'b0) begin errors++; $display("FAIL sw_mem got %b %b exp 1 0", bus.mem_MemWrite, bus.mem_MemRead); end
        tick();
        checks++; if (bus.mem_MemRead !== 1'b1 || bus.mem_MemWrite !== 1'b0) begin errors++; $display("FAIL lw_mem got %b %b exp 1 0", bus.mem_MemRead, bus.mem_MemWrite); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (bus.mem_MemRead !== 1'b0 || bus.wb_RegWrite !== 1'b0) begin errors++; $display("FAIL midrst got %b %b exp 0 0", bus.mem_MemRead, bus.wb_RegWrite); end
    endtask

    initial begin
        reset = 1;
        clear_id();
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_jump();
        test_back_to_back_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
